mems_scan_gen: RTL and testbench
================================

# mems_scan_gen

Parametrised MEMS scan timing generator: produces line and frame event flags at a programmable line period and lines-per-frame, each held until the FIFO writer acknowledges it. Sits between the clock domain root and the FIFO write controller, replacing the fixed-timing scan stub. Adds runtime configuration, enable/disable, line/frame indices, overrun detection and optional vertical blanking.

## Interface
- CNT_W, 30: width of line-period counter.
- LINE_W, 8: width of line counter / lines_per_frame.
- FRM_W, 16: width of frame counter.
- DEF_PERIOD, 1000000: line_period loaded at reset.
- DEF_LINES, 16: lines_per_frame loaded at reset.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run scan while high.
- cfg_load  in  1  request to latch line_period/lines_per_frame into shadow registers.
- line_period  in  CNT_W  cycles between events.
- lines_per_frame  in  LINE_W  events per frame (last one is the frame event).
- new_line_done  in  1  FIFO acknowledges new_line.
- new_frame_done  in  1  FIFO acknowledges new_frame.
- new_line  out  1  line event flag, held until acknowledged.
- new_frame  out  1  frame event flag, held until acknowledged.
- line_idx  out  LINE_W  current line within frame.
- frame_cnt  out  FRM_W  completed frames, wraps.
- overrun  out  1  sticky: an event fired while its flag was still set.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, BLANK (BLANK only with macro). Reset -> IDLE.
- IDLE: counters held at 0; enable=1 -> RUN next cycle.
- RUN: period counter counts 0..P-1; at P-1 an event fires, counter returns to 0.
- Event: if line_idx < L-1 -> set new_line, line_idx+1; else -> set new_frame, line_idx=0, frame_cnt+1 (wraps at 2^FRM_W).
- P = shadow line_period, clamped to minimum 2; L = shadow lines_per_frame, 0 treated as 1 (every event is a frame event).
- Shadow load: cfg_load in IDLE takes effect immediately; cfg_load in RUN/BLANK is pended and applied on the cycle the next frame event fires. Last request wins.
- Flags: done=1 clears its flag next cycle; set and done in same cycle -> flag stays 1 (set wins).
- Overrun: event fires while its flag is already 1 -> overrun=1 (cleared only by rst); flag stays 1.
- enable falling in RUN/BLANK -> IDLE next cycle; period counter, line_idx cleared; flags, frame_cnt, overrun, pending cfg retained.
- Reset mid-operation: all state returns to reset values in one cycle.
- Reset values: new_line=0, new_frame=0, line_idx=0, frame_cnt=0, overrun=0, busy=0; shadows = DEF_PERIOD/DEF_LINES.

## Timing
- enable sampled high at edge k -> busy=1 after edge k+1; first event flag high after edge k+P.
- Subsequent events every P cycles (without blanking).
- done sampled at edge n -> flag low after edge n.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- MEMS_SCAN_BLANK_EN defined: adds input blank_len [CNT_W] and output in_blank [1]. After each frame event, state BLANK for blank_len cycles (0 = skip BLANK), in_blank=1, period counter held at 0; then RUN. Next event fires P cycles after leaving BLANK.
- Undefined: no BLANK state, no extra ports; RUN continues directly after frame event.

## Structure
- Package mems_scan_pkg: state enum, DEF_PERIOD/DEF_LINES defaults, minimum-period constant.
- Sub-module mems_evt_flag: set/clear/set-wins flag with overrun output; instantiated twice (line, frame); top ORs overruns into sticky register.

## Test plan
- P=4, L=3, enable at cycle 0, done pulsed 1 cycle after each flag -> new_line at 4, 8; new_frame at 12; line_idx 0,1,2,0; frame_cnt=1.
- Never acknowledge new_line, P=4, L=8 -> new_line stays 1, overrun=1 after second event (cycle 8) and remains 1 after enable=0.
- line_period=0, L=0 -> treated P=2, L=1: new_frame every 2 cycles, frame_cnt increments each event.
- cfg_load P=10 mid-frame with P=4, L=4 -> current frame keeps 4-cycle spacing; period 10 from the frame event onward.
- Set and done coincide on new_frame -> flag remains 1, no overrun.
- With MEMS_SCAN_BLANK_EN, blank_len=5, P=4, L=2 -> in_blank high 5 cycles after each frame event; next new_line 9 cycles after frame event.

Source files
------------

// File: rtl/mems_scan_pkg.sv
// Shared types and defaults for the MEMS scan timing generator.
package mems_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_e;

   localparam int SCAN_DEF_PERIOD = 1000000;
   localparam int SCAN_DEF_LINES  = 16;
   // A one-cycle period would make back-to-back events indistinguishable.
   localparam int SCAN_MIN_PERIOD = 2;

endpackage

// File: rtl/mems_evt_flag.sv
// Event flag held until acknowledged; a set in the same cycle as done wins.
// ovr reports an event landing on a flag that is still pending and not being acked.
module mems_evt_flag (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic done,
   output logic flag,
   output logic ovr
);

   logic flag_d, flag_q;

   always_comb begin
      flag_d = flag_q;
      if (done) flag_d = 1'b0;
      if (set)  flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) flag_q <= 1'b0;
      else     flag_q <= flag_d;
   end

   assign flag = flag_q;
   assign ovr  = set & flag_q & ~done;

endmodule

// File: rtl/mems_scan_gen.sv
// MEMS scan timing generator: line/frame event flags at a programmable period.
// Define MEMS_SCAN_BLANK_EN to add a vertical blanking state after each frame event.
module mems_scan_gen
   import mems_scan_pkg::*;
#(
   parameter int CNT_W      = 30,
   parameter int LINE_W     = 8,
   parameter int FRM_W      = 16,
   parameter int DEF_PERIOD = SCAN_DEF_PERIOD,
   parameter int DEF_LINES  = SCAN_DEF_LINES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              cfg_load,
   input  logic [CNT_W-1:0]  line_period,
   input  logic [LINE_W-1:0] lines_per_frame,
   input  logic              new_line_done,
   input  logic              new_frame_done,
`ifdef MEMS_SCAN_BLANK_EN
   input  logic [CNT_W-1:0]  blank_len,
   output logic              in_blank,
`endif
   output logic              new_line,
   output logic              new_frame,
   output logic [LINE_W-1:0] line_idx,
   output logic [FRM_W-1:0]  frame_cnt,
   output logic              overrun,
   output logic              busy
);

   scan_state_e       state_d, state_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [LINE_W-1:0] line_idx_d, line_idx_q;
   logic [FRM_W-1:0]  frame_cnt_d, frame_cnt_q;
   logic [CNT_W-1:0]  shd_period_d, shd_period_q;
   logic [LINE_W-1:0] shd_lines_d, shd_lines_q;
   logic              pend_d, pend_q;
   logic [CNT_W-1:0]  pend_period_d, pend_period_q;
   logic [LINE_W-1:0] pend_lines_d, pend_lines_q;
   logic              overrun_d, overrun_q;
   logic              busy_d, busy_q;
`ifdef MEMS_SCAN_BLANK_EN
   logic [CNT_W-1:0]  blank_cnt_d, blank_cnt_q;
   logic              in_blank_d, in_blank_q;
`endif

   logic [CNT_W-1:0]  p_eff;
   logic [LINE_W-1:0] l_eff;
   logic              evt, last_line, line_set, frame_set, line_ovr, frame_ovr;

   assign p_eff     = (shd_period_q < CNT_W'(SCAN_MIN_PERIOD)) ? CNT_W'(SCAN_MIN_PERIOD) : shd_period_q;
   assign l_eff     = (shd_lines_q == '0) ? LINE_W'(1) : shd_lines_q;
   assign evt       = (state_q == ST_RUN) && enable && (cnt_q == p_eff - CNT_W'(1));
   assign last_line = (line_idx_q >= l_eff - LINE_W'(1));
   assign line_set  = evt && !last_line;
   assign frame_set = evt && last_line;

   mems_evt_flag u_line_flag (
      .clk  (clk),
      .rst  (rst),
      .set  (line_set),
      .done (new_line_done),
      .flag (new_line),
      .ovr  (line_ovr)
   );

   mems_evt_flag u_frame_flag (
      .clk  (clk),
      .rst  (rst),
      .set  (frame_set),
      .done (new_frame_done),
      .flag (new_frame),
      .ovr  (frame_ovr)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      line_idx_d    = line_idx_q;
      frame_cnt_d   = frame_cnt_q;
      shd_period_d  = shd_period_q;
      shd_lines_d   = shd_lines_q;
      pend_d        = pend_q;
      pend_period_d = pend_period_q;
      pend_lines_d  = pend_lines_q;
      overrun_d     = overrun_q | line_ovr | frame_ovr;
`ifdef MEMS_SCAN_BLANK_EN
      blank_cnt_d   = blank_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            cnt_d      = '0;
            line_idx_d = '0;
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               line_idx_d = '0;
            end else if (evt) begin
               cnt_d = '0;
               if (last_line) begin
                  line_idx_d  = '0;
                  frame_cnt_d = frame_cnt_q + FRM_W'(1);
`ifdef MEMS_SCAN_BLANK_EN
                  if (blank_len != '0) begin
                     state_d     = ST_BLANK;
                     blank_cnt_d = '0;
                  end
`endif
               end else begin
                  line_idx_d = line_idx_q + LINE_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef MEMS_SCAN_BLANK_EN
         ST_BLANK: begin
            cnt_d = '0;
            if (!enable) begin
               state_d    = ST_IDLE;
               line_idx_d = '0;
            end else if ((blank_cnt_q + CNT_W'(1)) >= blank_len) begin
               state_d = ST_RUN;
            end else begin
               blank_cnt_d = blank_cnt_q + CNT_W'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // While scanning, config waits for a frame boundary; the newest request wins.
      if (cfg_load) begin
         pend_period_d = line_period;
         pend_lines_d  = lines_per_frame;
      end
      if (state_q == ST_IDLE) begin
         if (cfg_load) begin
            shd_period_d = line_period;
            shd_lines_d  = lines_per_frame;
            pend_d       = 1'b0;
         end
      end else begin
         if (cfg_load) pend_d = 1'b1;
         if (frame_set && (pend_q || cfg_load)) begin
            shd_period_d = pend_period_d;
            shd_lines_d  = pend_lines_d;
            pend_d       = 1'b0;
         end
      end

      busy_d = (state_q != ST_IDLE);
`ifdef MEMS_SCAN_BLANK_EN
      in_blank_d = (state_d == ST_BLANK);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         line_idx_q    <= '0;
         frame_cnt_q   <= '0;
         shd_period_q  <= CNT_W'(DEF_PERIOD);
         shd_lines_q   <= LINE_W'(DEF_LINES);
         pend_q        <= 1'b0;
         pend_period_q <= '0;
         pend_lines_q  <= '0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
`ifdef MEMS_SCAN_BLANK_EN
         blank_cnt_q   <= '0;
         in_blank_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         line_idx_q    <= line_idx_d;
         frame_cnt_q   <= frame_cnt_d;
         shd_period_q  <= shd_period_d;
         shd_lines_q   <= shd_lines_d;
         pend_q        <= pend_d;
         pend_period_q <= pend_period_d;
         pend_lines_q  <= pend_lines_d;
         overrun_q     <= overrun_d;
         busy_q        <= busy_d;
`ifdef MEMS_SCAN_BLANK_EN
         blank_cnt_q   <= blank_cnt_d;
         in_blank_q    <= in_blank_d;
`endif
      end
   end

   assign line_idx  = line_idx_q;
   assign frame_cnt = frame_cnt_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;
`ifdef MEMS_SCAN_BLANK_EN
   assign in_blank  = in_blank_q;
`endif

endmodule

// File: tb/tb_mems_scan_gen.sv
// Directed bench for mems_scan_gen: each flag rising edge is matched against an
// expected {cycle, kind, line_idx, frame_cnt} entry queued when stimulus is driven.
module tb_mems_scan_gen;

   localparam int CNT_W  = 30;
   localparam int LINE_W = 8;
   localparam int FRM_W  = 16;
   localparam int EW     = 32 + 1 + LINE_W + FRM_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic              cfg_load = 1'b0;
   logic [CNT_W-1:0]  line_period = '0;
   logic [LINE_W-1:0] lines_per_frame = '0;
   logic              new_line_done, new_frame_done;
   logic              new_line, new_frame, overrun, busy;
   logic [LINE_W-1:0] line_idx;
   logic [FRM_W-1:0]  frame_cnt;
`ifdef MEMS_SCAN_BLANK_EN
   logic [CNT_W-1:0]  blank_len = '0;
   logic              in_blank;
`endif

   logic auto_line = 1'b0, auto_frame = 1'b0;
   logic ack_line = 1'b0, ack_frame = 1'b0;
   logic man_line_done = 1'b0, man_frame_done = 1'b0;
   logic prev_line = 1'b0, prev_frame = 1'b0;

   assign new_line_done  = ack_line | man_line_done;
   assign new_frame_done = ack_frame | man_frame_done;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int k;
   int exp_frames = 0;
   logic [EW-1:0] exp_q[$];

   mems_scan_gen dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .cfg_load        (cfg_load),
      .line_period     (line_period),
      .lines_per_frame (lines_per_frame),
      .new_line_done   (new_line_done),
      .new_frame_done  (new_frame_done),
`ifdef MEMS_SCAN_BLANK_EN
      .blank_len       (blank_len),
      .in_blank        (in_blank),
`endif
      .new_line        (new_line),
      .new_frame       (new_frame),
      .line_idx        (line_idx),
      .frame_cnt       (frame_cnt),
      .overrun         (overrun),
      .busy            (busy)
   );

   // clock / reset timebase
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic fr, input int li, input int fc);
      exp_q.push_back({32'(c), fr, LINE_W'(li), FRM_W'(fc)});
   endtask

   task automatic cfg(input int period, input int lines);
      cfg_load        = 1'b1;
      line_period     = CNT_W'(period);
      lines_per_frame = LINE_W'(lines);
      tick(1);
      cfg_load = 1'b0;
   endtask

   task automatic score(input logic fr);
      logic [EW-1:0] obs;
      logic [EW-1:0] expv;
      obs = {32'(cyc), fr, line_idx, frame_cnt};
      check("evt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         expv = exp_q.pop_front();
         check("evt", 64'(obs), 64'(expv));
      end
   endtask

   // scoreboard monitor and auto-acknowledge driver, both on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (new_line && !prev_line)   score(1'b0);
            if (new_frame && !prev_frame) score(1'b1);
         end
         prev_line  = new_line;
         prev_frame = new_frame;
         ack_line   = auto_line && new_line;
         ack_frame  = auto_frame && new_frame;
      end
   end

   initial begin
      // reset state
      tick(3);
      check("rst_new_line", 64'(new_line), 64'd0);
      check("rst_new_frame", 64'(new_frame), 64'd0);
      check("rst_line_idx", 64'(line_idx), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick(1);

      // P=4, L=3, acked one cycle after each flag
      cfg(4, 3);
      auto_line  = 1'b1;
      auto_frame = 1'b1;
      k = cyc + 1;
      enable = 1'b1;
      push(k + 4, 1'b0, 1, 0);
      push(k + 8, 1'b0, 2, 0);
      push(k + 12, 1'b1, 0, 1);
      tick(1);
      check("busy_lag", 64'(busy), 64'd0);
      tick(1);
      check("busy_on", 64'(busy), 64'd1);
      tick(12);
      check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
      check("t1_line_idx", 64'(line_idx), 64'd0);
      check("t1_overrun", 64'(overrun), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      enable = 1'b0;
      tick(2);
      check("t1_busy_off", 64'(busy), 64'd0);
      exp_frames = 1;

      // new_line never acknowledged: overrun at the second event
      cfg(4, 8);
      auto_line = 1'b0;
      k = cyc + 1;
      enable = 1'b1;
      push(k + 4, 1'b0, 1, exp_frames);
      tick(8);
      check("t2_no_overrun_yet", 64'(overrun), 64'd0);
      check("t2_line_held", 64'(new_line), 64'd1);
      tick(1);
      check("t2_overrun", 64'(overrun), 64'd1);
      check("t2_line_idx", 64'(line_idx), 64'd2);
      check("t2_line_still", 64'(new_line), 64'd1);
      enable = 1'b0;
      tick(2);
      check("t2_overrun_sticky", 64'(overrun), 64'd1);
      check("t2_line_retained", 64'(new_line), 64'd1);
      check("t2_line_idx_clr", 64'(line_idx), 64'd0);
      check("t2_frame_cnt_kept", 64'(frame_cnt), 64'(exp_frames));
      man_line_done = 1'b1;
      tick(1);
      man_line_done = 1'b0;
      check("t2_line_acked", 64'(new_line), 64'd0);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("t2_overrun_rst", 64'(overrun), 64'd0);
      check("t2_frame_cnt_rst", 64'(frame_cnt), 64'd0);
      exp_frames = 0;
      auto_line = 1'b1;

      // period 0 and zero lines clamp to P=2, L=1; then a mid-run reset
      cfg(0, 0);
      k = cyc + 1;
      enable = 1'b1;
      for (int i = 1; i <= 4; i++) push(k + 2 * i, 1'b1, 0, i);
      tick(9);
      check("t3_frame_cnt", 64'(frame_cnt), 64'd4);
      rst    = 1'b1;
      enable = 1'b0;
      tick(1);
      rst = 1'b0;
      check("t3_rst_busy", 64'(busy), 64'd0);
      check("t3_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("t3_rst_frame", 64'(new_frame), 64'd0);
      check("t3_rst_line_idx", 64'(line_idx), 64'd0);
      tick(4);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // mid-frame reconfiguration waits for the frame event
      cfg(4, 4);
      k = cyc + 1;
      enable = 1'b1;
      push(k + 4, 1'b0, 1, 0);
      push(k + 8, 1'b0, 2, 0);
      push(k + 12, 1'b0, 3, 0);
      push(k + 16, 1'b1, 0, 1);
      push(k + 26, 1'b0, 1, 1);
      push(k + 36, 1'b0, 2, 1);
      tick(6);
      cfg(10, 4);
      tick(31);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      check("t4_overrun", 64'(overrun), 64'd0);
      enable = 1'b0;
      tick(2);
      exp_frames = 1;

      // ack arrives on the same edge as the next frame event: set wins, no overrun
      cfg(4, 1);
      auto_frame = 1'b0;
      k = cyc + 1;
      enable = 1'b1;
      push(k + 4, 1'b1, 0, exp_frames + 1);
      tick(8);
      man_frame_done = 1'b1;
      tick(1);
      man_frame_done = 1'b0;
      check("t5_frame_set_wins", 64'(new_frame), 64'd1);
      check("t5_no_overrun", 64'(overrun), 64'd0);
      check("t5_frame_cnt", 64'(frame_cnt), 64'(exp_frames + 2));
      tick(1);
      check("t5_frame_held", 64'(new_frame), 64'd1);
      man_frame_done = 1'b1;
      tick(1);
      man_frame_done = 1'b0;
      enable = 1'b0;
      check("t5_frame_cleared", 64'(new_frame), 64'd0);
      tick(2);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
      exp_frames = exp_frames + 2;
      auto_frame = 1'b1;

`ifdef MEMS_SCAN_BLANK_EN
      // 5-cycle blanking after each frame event, P=4, L=2
      blank_len = CNT_W'(5);
      cfg(4, 2);
      k = cyc + 1;
      enable = 1'b1;
      push(k + 4, 1'b0, 1, exp_frames);
      push(k + 8, 1'b1, 0, exp_frames + 1);
      push(k + 17, 1'b0, 1, exp_frames + 1);
      push(k + 21, 1'b1, 0, exp_frames + 2);
      tick(8);
      check("bl_before", 64'(in_blank), 64'd0);
      tick(1);
      check("bl_first", 64'(in_blank), 64'd1);
      tick(4);
      check("bl_last", 64'(in_blank), 64'd1);
      tick(1);
      check("bl_exit", 64'(in_blank), 64'd0);
      tick(9);
      check("bl_second", 64'(in_blank), 64'd1);
      enable = 1'b0;
      tick(1);
      check("bl_disable", 64'(in_blank), 64'd0);
      blank_len = '0;
      tick(2);
      check("bl_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

      tick(3);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
